// File: rtl/sdreq_arb_pkg.sv
// Shared types and constants for the SDRAM request arbiter.
// Holds the FSM state encoding and the channel bundle widths.
package sdreq_arb_pkg;

    localparam int NCH             = 4;
    localparam int SA_W            = 22;
    localparam int PARAM_W         = 6;
    localparam int REFR_PERIOD_DEF = 780;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/sdreq_rr4.sv
// Combinational 4-way round-robin priority encoder.
// Priority starts at the channel after the last grant.
module sdreq_rr4
    import sdreq_arb_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  logic [1:0]     last,
    output logic [NCH-1:0] gnt,
    output logic [1:0]     idx
);

    logic [1:0] c;

    // Walk from lowest to highest priority so the nearest requester wins.
    always_comb begin
        gnt = '0;
        idx = last;
        c   = last;
        for (int i = NCH; i >= 1; i--) begin
            c = last + 2'(i);
            if (req[c]) begin
                gnt    = '0;
                gnt[c] = 1'b1;
                idx    = c;
            end
        end
    end

endmodule

// File: rtl/sdreq_arb.sv
// Round-robin request arbiter and refresh scheduler ahead of sdseq.
// Define SDREQ_ARB_REFR_POSTPONE_EN to let transfers postpone refresh.
module sdreq_arb
    import sdreq_arb_pkg::*;
#(
    parameter int REFR_PERIOD   = REFR_PERIOD_DEF,
    parameter int REFR_MAX_PEND = 8,
    parameter int TOUT_CYC      = 255
) (
    input  logic                 clk0,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*SA_W-1:0]  ch_sa,
    input  logic [NCH*PARAM_W-1:0] ch_param,
    input  logic [NCH-1:0]       ch_wnr,
    input  logic                 ch2_mode,
    input  logic                 next,
    output logic [NCH-1:0]       ack,
    output logic                 xfer,
    output logic                 refr,
    output logic [SA_W-1:0]      sa,
    output logic [1:0]           chsel,
    output logic [PARAM_W-1:0]   param,
    output logic                 wnr,
    output logic                 mode,
    output logic                 busy,
    output logic                 refr_ovf,
    output logic                 tout
);

    localparam int RC_W = $clog2(REFR_PERIOD);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFR_PERIOD - 1);
    localparam logic [7:0] TOUT_LAST = 8'(TOUT_CYC - 1);

`ifdef SDREQ_ARB_REFR_POSTPONE_EN
    localparam int PEND_W = 4;
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(REFR_MAX_PEND);
    localparam logic [PEND_W-1:0] PEND_HALF = PEND_W'(REFR_MAX_PEND / 2);
`else
    localparam int PEND_W = 1;
    localparam logic [PEND_W-1:0] PEND_MAX = 1'b1;
`endif

    if (REFR_MAX_PEND < 2 || REFR_MAX_PEND > 15) begin : g_pend_chk
        $error("sdreq_arb: REFR_MAX_PEND out of range");
    end

    state_e              state_q, state_d;
    logic [RC_W-1:0]     rcnt_q, rcnt_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic [7:0]          tcnt_q, tcnt_d;
    logic [1:0]          last_q, last_d;
    logic [SA_W-1:0]     sa_q, sa_d;
    logic [1:0]          chsel_q, chsel_d;
    logic [PARAM_W-1:0]  param_q, param_d;
    logic                wnr_q, wnr_d;
    logic                mode_q, mode_d;
    logic                xfer_q, xfer_d;
    logic                refr_q, refr_d;
    logic [NCH-1:0]      ack_q, ack_d;
    logic                ovf_q, ovf_d;
    logic                tout_q, tout_d;

    logic                tick;
    logic                want_xfer;
    logic                refr_go;
    logic [NCH-1:0]      rr_gnt;
    logic [1:0]          rr_idx;

    sdreq_rr4 u_rr4 (
        .req  (req),
        .last (last_q),
        .gnt  (rr_gnt),
        .idx  (rr_idx)
    );

    // Refresh tick generator and pending-refresh bookkeeping.
    always_comb begin
        tick   = (rcnt_q == '0);
        rcnt_d = tick ? RC_LAST : rcnt_q - 1'b1;
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (tick && !refr_q) begin
            if (pend_q != PEND_MAX) begin
                pend_d = pend_q + 1'b1;
            end
        end else if (!tick && refr_q) begin
            pend_d = pend_q - 1'b1;
        end
`ifdef SDREQ_ARB_REFR_POSTPONE_EN
        if (pend_d == PEND_MAX) begin
            ovf_d = 1'b1;
        end
`else
        if (tick && pend_q == PEND_MAX) begin
            ovf_d = 1'b1;
        end
`endif
    end

    always_comb begin
        want_xfer = en && (req != '0);
`ifdef SDREQ_ARB_REFR_POSTPONE_EN
        refr_go = (pend_q >= PEND_HALF) || ((pend_q != '0) && !want_xfer);
`else
        refr_go = (pend_q != '0);
`endif
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        last_d  = last_q;
        sa_d    = sa_q;
        chsel_d = chsel_q;
        param_d = param_q;
        wnr_d   = wnr_q;
        mode_d  = mode_q;
        xfer_d  = 1'b0;
        refr_d  = 1'b0;
        ack_d   = '0;
        tout_d  = tout_q;
        unique case (state_q)
            IDLE: begin
                if (refr_go) begin
                    state_d = ISSUE;
                    refr_d  = 1'b1;
                end else if (want_xfer) begin
                    state_d = ISSUE;
                    xfer_d  = 1'b1;
                    ack_d   = rr_gnt;
                    last_d  = rr_idx;
                    chsel_d = rr_idx;
                    sa_d    = ch_sa[rr_idx*SA_W +: SA_W];
                    param_d = ch_param[rr_idx*PARAM_W +: PARAM_W];
                    wnr_d   = ch_wnr[rr_idx];
                    mode_d  = (rr_idx == 2'd2) && ch2_mode;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                tcnt_d  = '0;
            end
            WAIT: begin
                if (next) begin
                    state_d = IDLE;
                end else if (tcnt_q >= TOUT_LAST) begin
                    state_d = IDLE;
                    tout_d  = 1'b1;
                end else if (tcnt_q != 8'hFF) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(negedge clk0) begin
        if (rst) begin
            state_q <= IDLE;
            rcnt_q  <= RC_LAST;
            pend_q  <= '0;
            tcnt_q  <= '0;
            last_q  <= 2'd3;
            sa_q    <= '0;
            chsel_q <= '0;
            param_q <= '0;
            wnr_q   <= 1'b0;
            mode_q  <= 1'b0;
            xfer_q  <= 1'b0;
            refr_q  <= 1'b0;
            ack_q   <= '0;
            ovf_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            pend_q  <= pend_d;
            tcnt_q  <= tcnt_d;
            last_q  <= last_d;
            sa_q    <= sa_d;
            chsel_q <= chsel_d;
            param_q <= param_d;
            wnr_q   <= wnr_d;
            mode_q  <= mode_d;
            xfer_q  <= xfer_d;
            refr_q  <= refr_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
            tout_q  <= tout_d;
        end
    end

    assign ack      = ack_q;
    assign xfer     = xfer_q;
    assign refr     = refr_q;
    assign sa       = sa_q;
    assign chsel    = chsel_q;
    assign param    = param_q;
    assign wnr      = wnr_q;
    assign mode     = mode_q;
    assign busy     = (state_q != IDLE);
    assign refr_ovf = ovf_q;
    assign tout     = tout_q;

endmodule

// File: tb/tb_sdreq_arb.sv
// Scoreboard bench for sdreq_arb with a small sdseq responder model.
// Expected grants are queued at stimulus time and popped on each xfer.
module tb_sdreq_arb;
    import sdreq_arb_pkg::*;

    logic        clk0 = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  req = '0;
    logic [87:0] ch_sa = '0;
    logic [23:0] ch_param = '0;
    logic [3:0]  ch_wnr = '0;
    logic        ch2_mode = 1'b0;
    logic        next_r = 1'b0;
    logic        stray = 1'b0;
    logic        next_w;
    logic [3:0]  ack;
    logic        xfer, refr, wnr, mode, busy, refr_ovf, tout;
    logic [21:0] sa;
    logic [1:0]  chsel;
    logic [5:0]  param;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] sb[$];
    int          cyc = 0;
    int          xfer_cnt = 0;
    int          refr_t[$];
    int          pend_at_refr[$];
    bit          outstanding = 1'b0;
    bit          auto_next = 1'b0;
    bit          sb_on = 1'b1;
    int          wcnt = 0;
    int          nd = 4;
    logic        tout_prev = 1'b0;

    assign next_w = next_r | stray;

    sdreq_arb #(
        .REFR_PERIOD   (20),
        .REFR_MAX_PEND (8),
        .TOUT_CYC      (255)
    ) dut (
        .clk0     (clk0),
        .rst      (rst),
        .en       (en),
        .req      (req),
        .ch_sa    (ch_sa),
        .ch_param (ch_param),
        .ch_wnr   (ch_wnr),
        .ch2_mode (ch2_mode),
        .next     (next_w),
        .ack      (ack),
        .xfer     (xfer),
        .refr     (refr),
        .sa       (sa),
        .chsel    (chsel),
        .param    (param),
        .wnr      (wnr),
        .mode     (mode),
        .busy     (busy),
        .refr_ovf (refr_ovf),
        .tout     (tout)
    );

    always #5 clk0 = ~clk0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mkexp(input logic [1:0] ch,
        input logic [21:0] a, input logic [5:0] p, input logic w,
        input logic m);
        return {m, w, p, ch, a};
    endfunction

    task automatic set_ch(input int ch, input logic [21:0] a,
                          input logic [5:0] p, input logic w);
        ch_sa[ch*22 +: 22]   = a;
        ch_param[ch*6 +: 6]  = p;
        ch_wnr[ch]           = w;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk0);
        #1;
    endtask

    task automatic do_reset();
        tick(1);
        rst = 1'b1;
        req = '0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_xfer(input int target, input int bound,
                             input string tag, output int lat);
        lat = 0;
        while (xfer_cnt < target && lat < bound) begin
            tick(1);
            lat++;
        end
        chk(tag, {31'd0, xfer_cnt >= target}, 32'd1);
    endtask

    // Sequencer model: returns next nd cycles after each command.
    always @(posedge clk0) begin
        logic [31:0] e;
        cyc++;
        if (next_r) next_r = 1'b0;
        if (rst || (tout && !tout_prev)) begin
            outstanding = 1'b0;
            wcnt = 0;
        end
        tout_prev = tout;
        if (xfer || refr) begin
            chk("one_cmd", {31'd0, outstanding}, 32'd0);
            chk("xr_excl", {31'd0, xfer & refr}, 32'd0);
            outstanding = 1'b1;
            wcnt = 0;
            if (refr) begin
                refr_t.push_back(cyc);
                pend_at_refr.push_back(int'(dut.pend_q));
            end
            if (xfer) begin
                xfer_cnt++;
                if (sb_on) begin
                    chk("sb_has", {31'd0, sb.size() != 0}, 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("grant", {mode, wnr, param, chsel, sa}, e);
                        chk("ack", {28'd0, ack}, {28'd0, 4'b0001 << e[23:22]});
                    end
                end
            end
        end else if (outstanding && auto_next) begin
            wcnt++;
            if (wcnt >= nd) begin
                next_r = 1'b1;
                outstanding = 1'b0;
            end
        end
    end

    initial begin
        int lat, k, n, r0, p0, g, base;
        en = 1'b1;
        auto_next = 1'b1;
        tick(3);
        chk("rst_outs", {13'd0, xfer, refr, ack, busy, refr_ovf, tout,
                         chsel, param, wnr, mode}, 32'd0);
        chk("rst_sa", {10'd0, sa}, 32'd0);
        rst = 1'b0;

        // single request on channel 1
        set_ch(1, 22'h12345, 6'd5, 1'b1);
        req = 4'b0010;
        sb.push_back(mkexp(2'd1, 22'h12345, 6'd5, 1'b1, 1'b0));
        wait_xfer(1, 20, "t1_xfer", lat);
        req = '0;
        chk("t1_lat", lat, 32'd1);
        tick(2);
        chk("t1_hold", {busy, chsel, wnr, param, sa},
            {1'b1, 2'd1, 1'b1, 6'd5, 22'h12345});
        chk("t1_ack_clr", {28'd0, ack}, 32'd0);
        k = 2;
        while (busy && k < 30) begin
            tick(1);
            k++;
        end
        chk("t1_busy_fall", k, 32'd5);

        // round robin with all four requesting
        do_reset();
        ch2_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_ch(i, 22'h30000 + 22'(i * 'h111), 6'(8 + i), i[0]);
            sb.push_back(mkexp(2'(i), 22'h30000 + 22'(i * 'h111),
                               6'(8 + i), i[0], i == 2));
        end
        sb.push_back(mkexp(2'd0, 22'h30000, 6'd8, 1'b0, 1'b0));
        base = xfer_cnt;
        req = 4'b1111;
        wait_xfer(base + 5, 200, "t2_xfers", lat);
        req = '0;
        tick(10);
        chk("t2_sb_empty", sb.size(), 32'd0);

        // periodic refresh, no requests
        do_reset();
        r0 = refr_t.size();
        k = 0;
        while (refr_t.size() < r0 + 4 && k < 200) begin
            tick(1);
            k++;
        end
        n = refr_t.size();
        chk("t3_refr", {31'd0, n >= r0 + 4}, 32'd1);
        if (n >= r0 + 3) begin
            chk("t3_gap1", refr_t[n-1] - refr_t[n-2], 32'd20);
            chk("t3_gap2", refr_t[n-2] - refr_t[n-3], 32'd20);
        end
        tick(5);
        chk("t3_pend0", int'(dut.pend_q), 32'd0);

`ifdef SDREQ_ARB_REFR_POSTPONE_EN
        // transfers postpone refresh until half the limit is pending
        do_reset();
        sb_on = 1'b0;
        p0 = pend_at_refr.size();
        req = 4'b1111;
        k = 0;
        while (pend_at_refr.size() <= p0 && k < 300) begin
            tick(1);
            k++;
        end
        chk("t4_refr_seen", {31'd0, pend_at_refr.size() > p0}, 32'd1);
        if (pend_at_refr.size() > p0) begin
            chk("t4_first_pend", pend_at_refr[p0], 32'd4);
        end
        auto_next = 1'b0;
        tick(160);
        chk("t4_ovf", {31'd0, refr_ovf}, 32'd1);
        chk("t4_pend_max", int'(dut.pend_q), 32'd8);
        chk("t4_no_tout", {31'd0, tout}, 32'd0);
        req = '0;
        auto_next = 1'b1;
        tick(80);
        sb_on = 1'b1;
`else
        // a due refresh goes ahead of the next transfer
        do_reset();
        sb_on = 1'b0;
        r0 = refr_t.size();
        req = 4'b1111;
        tick(200);
        req = '0;
        n = refr_t.size() - r0;
        chk("t4_nrefr", {31'd0, n >= 9}, 32'd1);
        for (int j = r0 + 1; j < refr_t.size(); j++) begin
            g = refr_t[j] - refr_t[j-1];
            chk("t4_gap", {31'd0, g >= 14 && g <= 26}, 32'd1);
        end
        chk("t4_ovf_clr", {31'd0, refr_ovf}, 32'd0);
        tick(10);
        sb_on = 1'b1;
`endif

        // next never returned: 255 WAIT cycles after the ISSUE cycle
        do_reset();
        auto_next = 1'b0;
        set_ch(0, 22'h0ABCD, 6'h21, 1'b0);
        sb.push_back(mkexp(2'd0, 22'h0ABCD, 6'h21, 1'b0, 1'b0));
        base = xfer_cnt;
        req = 4'b0001;
        wait_xfer(base + 1, 20, "t5_xfer", lat);
        req = '0;
        k = 0;
        while (!tout && k < 400) begin
            tick(1);
            k++;
        end
        chk("t5_tout_cyc", k, 32'd256);
        chk("t5_idle", {31'd0, busy}, 32'd0);
        auto_next = 1'b1;
        set_ch(1, 22'h05555, 6'h0F, 1'b1);
        sb.push_back(mkexp(2'd1, 22'h05555, 6'h0F, 1'b1, 1'b0));
        req = 4'b0010;
        wait_xfer(base + 2, 300, "t5_regrant", lat);
        req = '0;
        chk("t5_tout_sticky", {31'd0, tout}, 32'd1);
        tick(10);

        // reset pulsed while waiting for next
        do_reset();
        auto_next = 1'b0;
        set_ch(2, 22'h2AAAA, 6'h03, 1'b1);
        sb.push_back(mkexp(2'd2, 22'h2AAAA, 6'h03, 1'b1, 1'b1));
        base = xfer_cnt;
        req = 4'b0100;
        wait_xfer(base + 1, 20, "t6_xfer", lat);
        req = '0;
        tick(2);
        chk("t6_in_wait", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("t6_rst_outs", {13'd0, xfer, refr, ack, busy, refr_ovf, tout,
                            chsel, param, wnr, mode}, 32'd0);
        chk("t6_rst_sa", {10'd0, sa}, 32'd0);
        stray = 1'b1;
        tick(1);
        stray = 1'b0;
        tick(1);
        chk("t6_stray", {29'd0, busy, xfer, refr}, 32'd0);
        auto_next = 1'b1;
        set_ch(0, 22'h1F00F, 6'h2A, 1'b0);
        sb.push_back(mkexp(2'd0, 22'h1F00F, 6'h2A, 1'b0, 1'b0));
        req = 4'b1111;
        wait_xfer(base + 2, 20, "t6_ch0_first", lat);
        req = '0;
        tick(10);
        chk("end_sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sdreq_arb.md
# sdreq_arb

Request arbiter and refresh scheduler sitting directly upstream of the SDRAM command sequencer (`sdseq`). It takes block-transfer requests from four channel buffers, selects one round-robin, and presents it to the sequencer as an `xfer` pulse with stable `sa`/`chsel`/`param`/`wnr`/`mode`. It also interleaves auto-refresh as `refr` pulses, and never issues a new command until the sequencer returns `next`. All registers are clocked on the falling edge of `clk0`, the same edge as the sequencer.

## Interface
Parameters:
- `REFR_PERIOD`, 780: cycles between refresh ticks (7.8 us at 100 MHz).
- `REFR_MAX_PEND`, 8: saturation limit of the pending-refresh counter (power of 2, 2..15).
- `TOUT_CYC`, 255: maximum cycles to wait for `next` before abandoning.

Ports (clock and reset first):
- `clk0` in 1: clock; all logic on the falling edge.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: arbitration enable; refresh still runs when low.
- `req` in 4: per-channel level request.
- `ch_sa` in 88: four 22-bit block start addresses [24:3]; channel n at [22n+21:22n].
- `ch_param` in 24: four 6-bit params.
- `ch_wnr` in 4: per-channel 1 = write to SDRAM.
- `ch2_mode` in 1: channel 2 mode (1 = 18x9); other channels force mode 0.
- `next` in 1: one-cycle pulse from the sequencer; it is ready for the next command.
- `ack` out 4: one-hot, one-cycle grant, coincident with `xfer`.
- `xfer` out 1: start block transfer.
- `refr` out 1: start auto-refresh.
- `sa` out 22: address [24:3] of the granted request.
- `chsel` out 2: granted channel.
- `param` out 6: granted parameter.
- `wnr` out 1: granted direction.
- `mode` out 1: granted mode.
- `busy` out 1: high from `xfer`/`refr` until `next` or timeout.
- `refr_ovf` out 1: sticky; pending counter hit `REFR_MAX_PEND`.
- `tout` out 1: sticky; `next` timeout occurred.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE → ISSUE when the refresh condition holds, or when `en` is high and `req` is non-zero.
  - Winner is latched into `sa`/`chsel`/`param`/`wnr`/`mode`.
- ISSUE (1 cycle): pulse either `refr`, or `xfer` together with the winner's `ack` bit. Next state is WAIT.
- WAIT → IDLE on `next`.
  - If `next` does not arrive within `TOUT_CYC` cycles, set `tout` and return to IDLE.
  - A `next` seen outside WAIT is ignored.
- Arbitration is round-robin over channels 0..3, starting at the channel after the last granted one. After reset the last grant is 3, so channel 0 has first priority.
- A `req` still high after `ack` counts as a new request. Requesters drop `req` on the cycle after `ack` if they have no further block.
- Refresh counter: counts `REFR_PERIOD-1` down to 0, reloads, and increments `pend`.
  - `pend` saturates at `REFR_MAX_PEND`; reaching it sets `refr_ovf`.
  - Issuing `refr` decrements `pend`.
  - A tick and an issue in the same cycle leave `pend` unchanged.
- Refresh has priority over transfers in IDLE when the refresh condition holds (see Configuration).
- Output latches (`sa`, `chsel`, `param`, `wnr`, `mode`) change only when entering ISSUE. They stay stable through WAIT, because the sequencer samples them up to 3 cycles after `xfer`.

## Timing
- Reset values:
  - all outputs 0;
  - `pend` = 0;
  - refresh counter = `REFR_PERIOD-1`;
  - FSM in IDLE; last grant = 3.
- `rst` mid-operation aborts any state to IDLE. The sequencer shares `rst`, so no `next` is owed.
- Latency:
  - `req` sampled high in IDLE at edge k → `xfer`+`ack` at edge k+1 → WAIT at k+2.
  - `next` at edge m → IDLE at m+1 → earliest new `xfer`/`refr` at m+2.
- `busy` = (state != IDLE).
- `xfer` and `refr` are never high together; at most one command is outstanding.
- Timeout counter is 8 bits, cleared on ISSUE, and saturates.

## Configuration
- `SDREQ_ARB_REFR_POSTPONE_EN` defined:
  - refresh is issued when `pend >= REFR_MAX_PEND/2`, or when `pend != 0` and no enabled request is pending;
  - transfers win otherwise.
- Undefined:
  - `pend` is a single bit (1 = due) and saturates at 1;
  - any due refresh is issued ahead of all transfers;
  - `refr_ovf` is set if a tick arrives while `pend` = 1.

## Structure
- Shared package `sdreq_arb_pkg`:
  - FSM state enum;
  - `NCH` = 4, `SA_W` = 22, `PARAM_W` = 6;
  - a default for `REFR_PERIOD`.
- One sub-module, `sdreq_rr4`: combinational 4-way round-robin priority encoder. Inputs are `req` and the last grant; outputs are a one-hot grant and a 2-bit index.

## Test plan
- Single request: ch1 `req`, `sa`=0x12345, `param`=5, `wnr`=1 → `xfer`+`ack`=0010 one cycle later, `chsel`=1, `sa`=0x12345.
  - Outputs stay stable until `next`; `busy` drops the cycle after `next`.
- Round-robin: all four `req` held high, `next` returned 4 cycles after each `xfer` → grants in order 0,1,2,3,0; never two `xfer` without an intervening `next`.
- Refresh: `REFR_PERIOD`=20, no requests → `refr` every 20 cycles (plus `next` turnaround); `pend` returns to 0.
- Postpone (macro on, `REFR_MAX_PEND`=8): continuous requests → first `refr` when `pend` reaches 4; with `next` withheld long enough, `refr_ovf` sets at `pend`=8.
  - Macro off: `refr` precedes the next `xfer` after each tick.
- Timeout: issue `xfer` and never return `next` → `tout`=1 after 255 cycles; FSM in IDLE; next request granted.
- Reset mid-WAIT: `rst` pulsed in WAIT → all outputs 0, channel 0 granted first after release; a stray `next` in IDLE has no effect.
